// File: rtl/baud_gen_ovs.sv
// Runtime-programmable UART baud generator: TX bit tick plus RX oversample/mid-bit ticks.
// Latency: all outputs are registered; a divisor load takes effect one edge after both channels are idle.
// Backpressure: none; ticks are free-running while the channel is enabled, and a divisor load is shadowed while busy.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_arst_n         asynchronous reset, active-low (priority over i_rst)
//   i_rst            synchronous clear, active-high
//   i_div_in         new divisor value (oversample period = divisor+1 clk)
//   i_div_load       1-cycle strobe capturing i_div_in
//   o_div_active     divisor currently in use
//   o_div_pending    captured divisor waiting for both channels to go idle
//   i_tx_en          TX channel run enable
//   o_tx_tick        1-cycle pulse once per bit period
//   i_rx_en          RX channel run enable
//   i_rx_restart     1-cycle strobe on start-bit falling edge (realigns RX phase)
//   o_rx_os_tick     1-cycle pulse once per oversample period
//   o_rx_sample_tick 1-cycle pulse at bit centre
module baud_gen_ovs #(
    parameter int                 WIDTH     = 16,
    parameter int                 OVS       = 16,
    parameter logic [WIDTH-1:0]   DIV_RESET = 16'd650
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_div_in,
    input  logic             i_div_load,
    output logic [WIDTH-1:0] o_div_active,
    output logic             o_div_pending,
    input  logic             i_tx_en,
    output logic             o_tx_tick,
    input  logic             i_rx_en,
    input  logic             i_rx_restart,
    output logic             o_rx_os_tick,
    output logic             o_rx_sample_tick
);

    localparam int               OW        = $clog2(OVS);
    localparam logic [OW-1:0]    OCNT_FULL = OW'(OVS - 1);
    // RX starts half a bit in so the first sample lands mid start bit.
    localparam logic [OW-1:0]    OCNT_HALF = OW'(OVS / 2 - 1);
    localparam logic [OW-1:0]    OCNT_ONE  = OW'(1);
    localparam logic [WIDTH-1:0] PCNT_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_div_active;
    logic [WIDTH-1:0] r_shadow;
    logic             r_div_pending;
    logic [WIDTH-1:0] r_tx_pcnt;
    logic [OW-1:0]    r_tx_ocnt;
    logic             r_tx_tick;
    logic [WIDTH-1:0] r_rx_pcnt;
    logic [OW-1:0]    r_rx_ocnt;
    logic             r_rx_os_tick;
    logic             r_rx_sample_tick;

    logic             w_idle;
    logic [WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0] w_shadow_next;
    logic             w_pending_next;

    assign w_idle = ~i_tx_en & ~i_rx_en;

    // The divisor may only change when neither channel is mid-frame; a fresh
    // load in the apply cycle beats the older shadowed value.
    always_comb begin
        w_div_next     = r_div_active;
        w_shadow_next  = r_shadow;
        w_pending_next = r_div_pending;
        if (w_idle) begin
            w_pending_next = 1'b0;
            if (i_div_load) begin
                w_div_next = i_div_in;
            end else if (r_div_pending) begin
                w_div_next = r_shadow;
            end
        end else if (i_div_load) begin
            w_shadow_next  = i_div_in;
            w_pending_next = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_div_active     <= DIV_RESET;
            r_shadow         <= DIV_RESET;
            r_div_pending    <= 1'b0;
            r_tx_pcnt        <= DIV_RESET;
            r_tx_ocnt        <= OCNT_FULL;
            r_tx_tick        <= 1'b0;
            r_rx_pcnt        <= DIV_RESET;
            r_rx_ocnt        <= OCNT_HALF;
            r_rx_os_tick     <= 1'b0;
            r_rx_sample_tick <= 1'b0;
        end else if (i_rst) begin
            r_div_active     <= DIV_RESET;
            r_shadow         <= DIV_RESET;
            r_div_pending    <= 1'b0;
            r_tx_pcnt        <= DIV_RESET;
            r_tx_ocnt        <= OCNT_FULL;
            r_tx_tick        <= 1'b0;
            r_rx_pcnt        <= DIV_RESET;
            r_rx_ocnt        <= OCNT_HALF;
            r_rx_os_tick     <= 1'b0;
            r_rx_sample_tick <= 1'b0;
        end else begin
            r_div_active  <= w_div_next;
            r_shadow      <= w_shadow_next;
            r_div_pending <= w_pending_next;

            // TX: a disabled channel preloads from the next divisor so a
            // divisor applied this edge is used by the very next period.
            if (!i_tx_en) begin
                r_tx_pcnt <= w_div_next;
                r_tx_ocnt <= OCNT_FULL;
                r_tx_tick <= 1'b0;
            end else if (r_tx_pcnt != '0) begin
                r_tx_pcnt <= r_tx_pcnt - PCNT_ONE;
                r_tx_tick <= 1'b0;
            end else begin
                r_tx_pcnt <= r_div_active;
                if (r_tx_ocnt == '0) begin
                    r_tx_ocnt <= OCNT_FULL;
                    r_tx_tick <= 1'b1;
                end else begin
                    r_tx_ocnt <= r_tx_ocnt - OCNT_ONE;
                    r_tx_tick <= 1'b0;
                end
            end

            // RX: restart realigns the phase and suppresses any tick due now.
            if (!i_rx_en) begin
                r_rx_pcnt        <= w_div_next;
                r_rx_ocnt        <= OCNT_HALF;
                r_rx_os_tick     <= 1'b0;
                r_rx_sample_tick <= 1'b0;
            end else if (i_rx_restart) begin
                r_rx_pcnt        <= r_div_active;
                r_rx_ocnt        <= OCNT_HALF;
                r_rx_os_tick     <= 1'b0;
                r_rx_sample_tick <= 1'b0;
            end else if (r_rx_pcnt != '0) begin
                r_rx_pcnt        <= r_rx_pcnt - PCNT_ONE;
                r_rx_os_tick     <= 1'b0;
                r_rx_sample_tick <= 1'b0;
            end else begin
                r_rx_pcnt    <= r_div_active;
                r_rx_os_tick <= 1'b1;
                if (r_rx_ocnt == '0) begin
                    r_rx_ocnt        <= OCNT_FULL;
                    r_rx_sample_tick <= 1'b1;
                end else begin
                    r_rx_ocnt        <= r_rx_ocnt - OCNT_ONE;
                    r_rx_sample_tick <= 1'b0;
                end
            end
        end
    end

    assign o_div_active     = r_div_active;
    assign o_div_pending    = r_div_pending;
    assign o_tx_tick        = r_tx_tick;
    assign o_rx_os_tick     = r_rx_os_tick;
    assign o_rx_sample_tick = r_rx_sample_tick;

endmodule
